// File: rtl/cbc_chain_ctrl.sv
// rtl/cbc_chain_ctrl.sv - ECB/CBC chaining controller driving an external block-cipher core
module cbc_chain_ctrl #(
    parameter int BLK_W       = 128,
    parameter int MAX_BLOCKS  = 64,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_len,
    input  logic [1:0]       cmd_mode,
    input  logic [BLK_W-1:0] cmd_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             core_start,
    output logic [BLK_W-1:0] core_din,
    output logic             core_decrypt,
    input  logic             core_busy,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [7:0]       csr_addr,
    output logic [31:0]      csr_rdata
);
    localparam int unsigned BLK_BYTES = BLK_W / 8;
    localparam int          TMO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [1:0]  M_ENC     = 2'd1;
    localparam logic [1:0]  M_DEC     = 2'd2;
    localparam logic [1:0]  M_BAD     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [BLK_W-1:0]   chain_q, chain_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   out_q, out_d;
    logic [31:0]        rem_q, rem_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   len_err_q, len_err_d;
    logic [CNT_W-1:0]   mode_err_q, mode_err_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0]   tmo_err_q, tmo_err_d;
    logic [31:0]        csr_q, csr_d;
    logic               len_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign len_bad = (cmd_len == 32'd0) || ((cmd_len % BLK_BYTES) != 32'd0)
                   || ((cmd_len / BLK_BYTES) > 32'(MAX_BLOCKS));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        chain_d    = chain_q;
        blk_d      = blk_q;
        out_d      = out_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        len_err_d  = len_err_q;
        mode_err_d = mode_err_q;
        pkt_cnt_d  = pkt_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        tmo_err_d  = tmo_err_q;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // A length fault takes precedence so only one error counter moves
                    if (len_bad) begin
                        err_d     = 1'b1;
                        len_err_d = sat_inc(len_err_q);
                    end else if (cmd_mode == M_BAD) begin
                        err_d      = 1'b1;
                        mode_err_d = sat_inc(mode_err_q);
                    end else begin
                        mode_d  = cmd_mode;
                        chain_d = cmd_iv;
                        rem_d   = cmd_len / BLK_BYTES;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_d   = in_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!core_busy) begin
                    core_start = 1'b1;
                    tmo_d      = TMO_W'(1);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_EMIT;
                    if (mode_q == M_ENC) begin
                        out_d   = core_dout;
                        chain_d = core_dout;
                    end else if (mode_q == M_DEC) begin
                        out_d   = core_dout ^ chain_q;
                        chain_d = blk_q;
                    end else begin
                        out_d = core_dout;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // err becomes visible exactly TIMEOUT_CYC cycles after core_start
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    tmo_err_d = sat_inc(tmo_err_q);
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    blk_cnt_d = sat_inc(blk_cnt_q);
                    rem_d     = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        pkt_cnt_d = sat_inc(pkt_cnt_q);
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        csr_d = 32'd0;
        case (csr_addr)
            8'h40:   csr_d = {8'd0, rem_q[7:0], 13'd0, mode_q, busy};
            8'h44:   csr_d = 32'(len_err_q);
            8'h48:   csr_d = 32'(mode_err_q);
            8'h4C:   csr_d = 32'(pkt_cnt_q);
            8'h50:   csr_d = 32'(blk_cnt_q);
            8'h54:   csr_d = 32'(tmo_err_q);
            default: csr_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            chain_q    <= '0;
            blk_q      <= '0;
            out_q      <= '0;
            rem_q      <= 32'd0;
            tmo_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_err_q  <= '0;
            mode_err_q <= '0;
            pkt_cnt_q  <= '0;
            blk_cnt_q  <= '0;
            tmo_err_q  <= '0;
            csr_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            chain_q    <= chain_d;
            blk_q      <= blk_d;
            out_q      <= out_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            err_q      <= err_d;
            len_err_q  <= len_err_d;
            mode_err_q <= mode_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            tmo_err_q  <= tmo_err_d;
            csr_q      <= csr_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign core_din     = (mode_q == M_ENC) ? (blk_q ^ chain_q) : blk_q;
    assign core_decrypt = (mode_q == M_DEC);
    assign out_data     = out_q;
    assign out_last     = (state_q == S_EMIT) && (rem_q == 32'd1);
    assign done         = done_q;
    assign err          = err_q;
    assign csr_rdata    = csr_q;
endmodule
